note_detector: RTL and testbench

Streaming multi-channel note detector: correlates a signed audio stream against `channels_p` externally generated quadrature reference tones over a fixed 2^`window_log2_p`-sample window. At window end it picks the strongest channel by |I|+|Q| magnitude and applies a detection threshold. It presents the result over a valid/ready output handshake. It sits between the line-in sample source plus per-note sinusoid generators and the display/UI logic, replacing the fixed seven-note, single-phase tuner datapath.

---
 rtl/note_detector.sv | 168 ++++++++++++++++
 tb/tb_note_detector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/note_detector.sv
`default_nettype none
// ============================================================================
// Module   : note_detector
// Brief    : Correlates a signed audio stream against quadrature reference
//            tones per channel over a 2^window_log2_p window, picks the
//            strongest channel by |I|+|Q| and flags it against a threshold.
// Revision : 1.0 - initial release
// ============================================================================
module note_detector #(
    parameter  int audio_width_p = 12,
    parameter  int ref_width_p   = 12,
    parameter  int channels_p    = 7,
    parameter  int window_log2_p = 16,
    localparam int idx_w         = $clog2(channels_p),
    localparam int acc_w         = audio_width_p + ref_width_p + window_log2_p,
    localparam int mag_w         = acc_w + 1
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic [audio_width_p-1:0]          audio_i,
    input  logic [channels_p*ref_width_p-1:0] ref_sin_i,
    input  logic [channels_p*ref_width_p-1:0] ref_cos_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic [mag_w-1:0]                  thresh_i,
    output logic [idx_w-1:0]                  note_o,
    output logic [mag_w-1:0]                  mag_o,
    output logic                              none_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              overrun_o
);

    localparam int                     PROD_W   = audio_width_p + ref_width_p;
    localparam logic [window_log2_p-1:0] CNT_LAST = '1;
    localparam logic [idx_w-1:0]       IDX_LAST = idx_w'(channels_p - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [window_log2_p-1:0]      r_cnt;
    logic                          w_win_end;
    logic [channels_p*mag_w-1:0]   w_snap_flat;
    logic [mag_w-1:0]              w_snap_cur;
    logic [idx_w-1:0]              r_idx;
    logic [idx_w-1:0]              r_arg;
    logic [mag_w-1:0]              r_max;
    logic [mag_w-1:0]              r_thresh;

    assign ready_o   = 1'b1;
    assign w_win_end = valid_i && (r_cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cnt <= '0;
        end else if (valid_i) begin
            r_cnt <= r_cnt + 1'b1;  // wraps to 0 after N-1
        end
    end

    // Per-channel I/Q accumulators; the window-end sample is folded straight
    // into the snapshot so the next window starts from zero with no gap.
    for (genvar k = 0; k < channels_p; k++) begin : g_ch
        logic signed [PROD_W-1:0] w_prod_i;
        logic signed [PROD_W-1:0] w_prod_q;
        logic signed [acc_w-1:0]  w_sum_i;
        logic signed [acc_w-1:0]  w_sum_q;
        logic        [acc_w-1:0]  w_abs_i;
        logic        [acc_w-1:0]  w_abs_q;
        logic signed [acc_w-1:0]  r_acc_i;
        logic signed [acc_w-1:0]  r_acc_q;
        logic        [mag_w-1:0]  r_snap;

        assign w_prod_i = $signed(audio_i) * $signed(ref_sin_i[k*ref_width_p +: ref_width_p]);
        assign w_prod_q = $signed(audio_i) * $signed(ref_cos_i[k*ref_width_p +: ref_width_p]);
        assign w_sum_i  = r_acc_i + acc_w'(w_prod_i);
        assign w_sum_q  = r_acc_q + acc_w'(w_prod_q);
        assign w_abs_i  = w_sum_i[acc_w-1] ? acc_w'(-w_sum_i) : acc_w'(w_sum_i);
        assign w_abs_q  = w_sum_q[acc_w-1] ? acc_w'(-w_sum_q) : acc_w'(w_sum_q);
        assign w_snap_flat[k*mag_w +: mag_w] = r_snap;

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                r_acc_i <= '0;
                r_acc_q <= '0;
                r_snap  <= '0;
            end else if (valid_i) begin
                if (w_win_end) begin
                    r_acc_i <= '0;
                    r_acc_q <= '0;
                    r_snap  <= {1'b0, w_abs_i} + {1'b0, w_abs_q};
                end else begin
                    r_acc_i <= w_sum_i;
                    r_acc_q <= w_sum_q;
                end
            end
        end
    end

    assign w_snap_cur = w_snap_flat[int'(r_idx)*mag_w +: mag_w];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_win_end) w_state_nxt = S_SCAN;
            S_SCAN:  if (r_idx == IDX_LAST) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_idx    <= '0;
            r_arg    <= '0;
            r_max    <= '0;
            r_thresh <= '0;
        end else begin
            if (w_win_end) begin
                r_thresh <= thresh_i;
                r_idx    <= '0;
            end else if (r_state == S_SCAN) begin
                r_idx <= r_idx + 1'b1;
                if ((r_idx == '0) || (w_snap_cur > r_max)) begin
                    r_max <= w_snap_cur;
                    r_arg <= r_idx;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            note_o    <= '0;
            mag_o     <= '0;
            none_o    <= 1'b0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else if (r_state == S_WRITE) begin
            note_o    <= r_arg;
            mag_o     <= r_max;
            none_o    <= (r_max < r_thresh);
            valid_o   <= 1'b1;
            overrun_o <= valid_o && !ready_i;
        end else begin
            overrun_o <= 1'b0;
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_note_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_detector
// Brief    : Directed self-checking bench for note_detector (3 channels, N=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_detector;

    localparam int AW = 12;
    localparam int RW = 12;
    localparam int CH = 3;
    localparam int WL = 3;
    localparam int IDX_W = $clog2(CH);
    localparam int MAG_W = AW + RW + WL + 1;

    logic                 clk_i = 1'b0;
    logic                 reset_ni = 1'b0;
    logic [AW-1:0]        audio_i = '0;
    logic [CH*RW-1:0]     ref_sin_i;
    logic [CH*RW-1:0]     ref_cos_i;
    logic                 valid_i = 1'b0;
    logic                 ready_o;
    logic [MAG_W-1:0]     thresh_i = '0;
    logic [IDX_W-1:0]     note_o;
    logic [MAG_W-1:0]     mag_o;
    logic                 none_o;
    logic                 valid_o;
    logic                 ready_i = 1'b1;
    logic                 overrun_o;

    logic signed [RW-1:0] sin_v [CH];
    logic signed [RW-1:0] cos_v [CH];

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    always_comb begin
        ref_sin_i = '0;
        ref_cos_i = '0;
        for (int k = 0; k < CH; k++) begin
            ref_sin_i[k*RW +: RW] = sin_v[k];
            ref_cos_i[k*RW +: RW] = cos_v[k];
        end
    end

    note_detector #(
        .audio_width_p(AW),
        .ref_width_p  (RW),
        .channels_p   (CH),
        .window_log2_p(WL)
    ) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .audio_i  (audio_i),
        .ref_sin_i(ref_sin_i),
        .ref_cos_i(ref_cos_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .thresh_i (thresh_i),
        .note_o   (note_o),
        .mag_o    (mag_o),
        .none_o   (none_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .overrun_o(overrun_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_refs(input int s0, input int s1, input int s2,
                            input int c0, input int c1, input int c2);
        sin_v[0] = RW'(s0); sin_v[1] = RW'(s1); sin_v[2] = RW'(s2);
        cos_v[0] = RW'(c0); cos_v[1] = RW'(c1); cos_v[2] = RW'(c2);
    endtask

    // n valid samples back to back, optionally with an idle cycle after each
    task automatic send(input int a, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            audio_i = AW'(a);
            valid_i = 1'b1;
            tick();
            valid_i = 1'b0;
            if (gaps) tick();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        set_refs(0, 0, 0, 0, 0, 0);
        idle(3);

        // Reset state
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_note", 64'(note_o), 64'd0);
        chk("rst_mag", 64'(mag_o), 64'd0);
        chk("rst_none", 64'(none_o), 64'd0);
        chk("rst_overrun", 64'(overrun_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        reset_ni = 1'b1;
        idle(1);
        chk("rel_valid", 64'(valid_o), 64'd0);
        chk("rel_ready", 64'(ready_o), 64'd1);

        // Mid-window reset: four partial samples must be discarded
        set_refs(0, 10, 0, 0, 0, 0);
        send(100, 4, 1'b0);
        #2 reset_ni = 1'b0;
        #3 reset_ni = 1'b1;
        idle(1);
        send(100, 8, 1'b0);
        idle(4);
        chk("midrst_valid", 64'(valid_o), 64'd1);
        chk("midrst_note", 64'(note_o), 64'd1);
        chk("midrst_mag", 64'(mag_o), 64'd8000);
        idle(2);

        // Single tone with latency check
        set_refs(0, 10, 0, 0, 0, 0);
        thresh_i = '0;
        send(100, 8, 1'b0);
        idle(3);
        chk("tone_lat_lo", 64'(valid_o), 64'd0);
        idle(1);
        chk("tone_lat_hi", 64'(valid_o), 64'd1);
        chk("tone_note", 64'(note_o), 64'd1);
        chk("tone_mag", 64'(mag_o), 64'd8000);
        chk("tone_none", 64'(none_o), 64'd0);
        idle(1);
        chk("tone_consumed", 64'(valid_o), 64'd0);

        // Quadrature with gaps: ch0 |-800|+|800|=1600, ch2 480
        set_refs(5, 0, 3, -5, 0, 0);
        send(-20, 8, 1'b1);
        idle(3);
        chk("quad_valid", 64'(valid_o), 64'd1);
        chk("quad_note", 64'(note_o), 64'd0);
        chk("quad_mag", 64'(mag_o), 64'd1600);
        idle(6);
        chk("quad_idle_note", 64'(note_o), 64'd0);
        chk("quad_idle_mag", 64'(mag_o), 64'd1600);

        // Tie between ch0 and ch2 resolves to the lower index
        set_refs(4, 0, 4, 0, 0, 0);
        send(50, 8, 1'b0);
        idle(4);
        chk("tie_valid", 64'(valid_o), 64'd1);
        chk("tie_note", 64'(note_o), 64'd0);
        chk("tie_mag", 64'(mag_o), 64'd1600);
        idle(2);

        // Threshold above and equal to the magnitude
        set_refs(0, 10, 0, 0, 0, 0);
        thresh_i = MAG_W'(9000);
        send(100, 8, 1'b0);
        idle(4);
        chk("thr9000_note", 64'(note_o), 64'd1);
        chk("thr9000_mag", 64'(mag_o), 64'd8000);
        chk("thr9000_none", 64'(none_o), 64'd1);
        idle(2);
        thresh_i = MAG_W'(8000);
        send(100, 8, 1'b0);
        idle(4);
        chk("thr8000_none", 64'(none_o), 64'd0);
        idle(2);
        thresh_i = '0;

        // Backpressure: second window overwrites an unaccepted result
        ready_i = 1'b0;
        set_refs(0, 10, 0, 0, 0, 0);
        send(100, 8, 1'b0);
        idle(4);
        chk("bp1_valid", 64'(valid_o), 64'd1);
        chk("bp1_note", 64'(note_o), 64'd1);
        chk("bp1_overrun", 64'(overrun_o), 64'd0);
        idle(3);
        chk("bp1_hold_note", 64'(note_o), 64'd1);
        chk("bp1_hold_valid", 64'(valid_o), 64'd1);
        set_refs(0, 0, 10, 0, 0, 0);
        send(100, 8, 1'b0);
        idle(3);
        chk("bp2_pre_overrun", 64'(overrun_o), 64'd0);
        idle(1);
        chk("bp2_overrun_hi", 64'(overrun_o), 64'd1);
        chk("bp2_note", 64'(note_o), 64'd2);
        chk("bp2_mag", 64'(mag_o), 64'd8000);
        chk("bp2_valid", 64'(valid_o), 64'd1);
        idle(1);
        chk("bp2_overrun_lo", 64'(overrun_o), 64'd0);
        chk("bp2_valid_hold", 64'(valid_o), 64'd1);
        ready_i = 1'b1;
        idle(1);
        chk("bp_release", 64'(valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
